// File: rtl/uartcon_tx_arb.sv
// uartcon_tx_arb: packet-level round-robin arbiter sharing the UART Tx FIFO write port
// between two byte-stream requesters, with a mid-packet stall timeout.
module uartcon_tx_arb #(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0_VALID,
    input  logic [7:0] REQ0_DATA,
    input  logic       REQ0_LAST,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [7:0] REQ1_DATA,
    input  logic       REQ1_LAST,
    output logic       REQ1_READY,
    output logic       WRITE,
    output logic [7:0] WDATA,
    input  logic       FULL,
    input  logic       AFULL,
    output logic [1:0] GRANT,
    output logic       ABORT
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_t          state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            write_q, write_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            abort_q, abort_d;
    logic            room, sel, sel_valid, sel_last, accept;
    logic [7:0]      sel_data;

    // A pending registered write may take the last free slot, so AFULL blocks only then.
    assign room       = !FULL && !(AFULL && write_q);
    assign sel        = (state_q == BUSY1);
    assign sel_valid  = sel ? REQ1_VALID : REQ0_VALID;
    assign sel_last   = sel ? REQ1_LAST : REQ0_LAST;
    assign sel_data   = sel ? REQ1_DATA : REQ0_DATA;
    assign REQ0_READY = (state_q == BUSY0) && room;
    assign REQ1_READY = (state_q == BUSY1) && room;
    assign accept     = (state_q != IDLE) && sel_valid && room;
    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);

    assign GRANT = {state_q == BUSY1, state_q == BUSY0};
    assign WRITE = write_q;
    assign WDATA = wdata_q;
    assign ABORT = abort_q;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        abort_d    = 1'b0;
        write_d    = accept;
        wdata_d    = accept ? sel_data : wdata_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (REQ0_VALID && (!REQ1_VALID || last_gnt_q))
                state_d = BUSY0;
            else if (REQ1_VALID)
                state_d = BUSY1;
        end else if (accept) begin
            cnt_d = '0;
            if (sel_last) begin
                state_d    = IDLE;
                last_gnt_d = sel;
            end
        end else if (!sel_valid) begin
            cnt_d = cnt_inc;
            if (TIMEOUT != 0 && cnt_inc >= TO_LIM) begin
                abort_d    = 1'b1;
                state_d    = IDLE;
                last_gnt_d = sel;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= 8'h00;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            abort_q    <= abort_d;
        end
    end
endmodule

// File: tb/tb_uartcon_tx_arb.sv
// tb_uartcon_tx_arb: vector table, directed corner sequences and a randomized
// packet-stream run checked against a FIFO/packet-order reference model.
module tb_uartcon_tx_arb;
    logic       CLK = 1'b0, RST_N = 1'b0;
    logic       REQ0_VALID = 1'b0, REQ0_LAST = 1'b0, REQ1_VALID = 1'b0, REQ1_LAST = 1'b0;
    logic [7:0] REQ0_DATA = 8'h00, REQ1_DATA = 8'h00;
    logic       FULL = 1'b0, AFULL = 1'b0;
    logic       REQ0_READY, REQ1_READY, WRITE, ABORT;
    logic [7:0] WDATA;
    logic [1:0] GRANT;

    int vectors = 0, miscompares = 0;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic v0; logic [7:0] d0; logic l0;
        logic v1; logic [7:0] d1; logic l1;
        logic full; logic afull;
        logic [1:0] g; logic r0; logic r1; logic wr; logic [7:0] wd; logic ab;
    } vec_t;

    always #5 CLK = ~CLK;

    uartcon_tx_arb #(.TIMEOUT(8), .TO_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_DATA(REQ0_DATA), .REQ0_LAST(REQ0_LAST), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_LAST(REQ1_LAST), .REQ1_READY(REQ1_READY),
        .WRITE(WRITE), .WDATA(WDATA), .FULL(FULL), .AFULL(AFULL), .GRANT(GRANT), .ABORT(ABORT)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        {REQ0_VALID, REQ0_LAST, REQ1_VALID, REQ1_LAST, FULL, AFULL} = '0;
        REQ0_DATA = 8'h00;
        REQ1_DATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    // Both requesters always present their next packet immediately, so the expected
    // FIFO stream is simply packets interleaved 0,1,0,1 with one idle cycle between grants.
    task automatic run_stream(input int npkt, input int max_gap, input int bp_pct, input bit fixed);
        logic [7:0] qd[2][$];
        bit         ql[2][$];
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [1:0] prev_g;
        int gap[2];
        int len, occ, idle_run, cyc;
        bit acc, pop;
        do_reset();
        for (int p = 0; p < npkt; p++)
            for (int r = 0; r < 2; r++) begin
                len = fixed ? 3 : int'($urandom_range(4, 1));
                for (int i = 0; i < len; i++) begin
                    b = fixed ? ((r == 1) ? 8'h61 : 8'h41) + 8'(i) : 8'($urandom_range(255));
                    qd[r].push_back(b);
                    ql[r].push_back(i == len - 1);
                    exp_q.push_back(b);
                end
            end
        gap[0] = 0; gap[1] = 0;
        occ = 0; idle_run = 0; cyc = 0; prev_g = 2'b00;
        while ((exp_q.size() > 0 || WRITE) && cyc < 5000) begin
            REQ0_VALID = qd[0].size() > 0 && gap[0] == 0;
            REQ0_DATA  = qd[0].size() > 0 ? qd[0][0] : 8'h00;
            REQ0_LAST  = qd[0].size() > 0 ? ql[0][0] : 1'b0;
            REQ1_VALID = qd[1].size() > 0 && gap[1] == 0;
            REQ1_DATA  = qd[1].size() > 0 ? qd[1][0] : 8'h00;
            REQ1_LAST  = qd[1].size() > 0 ? ql[1][0] : 1'b0;
            FULL  = occ >= DEPTH;
            AFULL = occ >= DEPTH - 1;
            @(negedge CLK);
            if (WRITE) begin
                check("fifo_room", occ < DEPTH, 1);
                if (exp_q.size() == 0) check("extra_write", WRITE, 0);
                else check("stream_byte", WDATA, exp_q.pop_front());
            end
            check("no_abort", ABORT, 0);
            check("grant_onehot", GRANT != 2'b11, 1);
            if (GRANT != 2'b00 && GRANT != prev_g)
                check("one_idle_between", prev_g == 2'b00 && idle_run == 1, 1);
            idle_run = (GRANT == 2'b00) ? idle_run + 1 : 0;
            prev_g = GRANT;
            for (int r = 0; r < 2; r++) begin
                acc = (r == 1) ? (REQ1_VALID && REQ1_READY) : (REQ0_VALID && REQ0_READY);
                if (acc) begin
                    gap[r] = ql[r][0] ? 0 : int'($urandom_range(max_gap, 0));
                    void'(qd[r].pop_front());
                    void'(ql[r].pop_front());
                end else if (gap[r] > 0) gap[r]--;
            end
            pop = occ > 0 && int'($urandom_range(99)) >= bp_pct;
            occ = occ + (WRITE ? 1 : 0) - (pop ? 1 : 0);
            cyc++;
            step();
        end
        check("stream_complete", exp_q.size(), 0);
        check("stream_in_budget", cyc < 5000, 1);
        {REQ0_VALID, REQ1_VALID, FULL, AFULL} = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[15];
        int idx, wi;
        tbl[0]  = '{1'b1, 8'h4F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'h4F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'h4B, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h4F, 1'b0};
        tbl[3]  = '{1'b1, 8'h0D, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'h4B, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h0D, 1'b0};
        tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h0D, 1'b0};
        tbl[7]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 8'h0D, 1'b0};
        tbl[8]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h72, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h71, 1'b0};
        tbl[9]  = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h72, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h71, 1'b0};
        tbl[10] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h73, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 8'h72, 1'b0};
        tbl[11] = '{1'b1, 8'h55, 1'b1, 1'b1, 8'h73, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 8'h72, 1'b0};
        tbl[12] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h73, 1'b0};
        tbl[13] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h73, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            {REQ0_VALID, REQ0_DATA, REQ0_LAST} = {tbl[i].v0, tbl[i].d0, tbl[i].l0};
            {REQ1_VALID, REQ1_DATA, REQ1_LAST} = {tbl[i].v1, tbl[i].d1, tbl[i].l1};
            {FULL, AFULL} = {tbl[i].full, tbl[i].afull};
            @(negedge CLK);
            check($sformatf("tbl[%0d] {grant,rdy0,rdy1,write,wdata,abort}", i),
                  {GRANT, REQ0_READY, REQ1_READY, WRITE, WDATA, ABORT},
                  {tbl[i].g, tbl[i].r0, tbl[i].r1, tbl[i].wr, tbl[i].wd, tbl[i].ab});
            step();
        end

        run_stream(3, 0, 0, 1'b1);
        run_stream(25, 3, 60, 1'b0);
        run_stream(25, 3, 0, 1'b0);

        // REQ1 packet under forced AFULL then FULL; stalls must never count toward timeout.
        do_reset();
        idx = 0; wi = 0;
        for (int c = 0; c < 30; c++) begin
            REQ1_VALID = idx < 8;
            REQ1_DATA  = 8'h80 + 8'(idx);
            REQ1_LAST  = idx == 7;
            AFULL = c >= 4 && c <= 8;
            FULL  = c >= 9 && c <= 18;
            @(negedge CLK);
            if (WRITE) begin
                check("s3_wdata", WDATA, 8'h80 + 8'(wi));
                wi++;
            end
            if (c >= 10 && c <= 18) check("s3_no_write_full", WRITE, 0);
            if (FULL || (AFULL && WRITE)) check("s3_ready_blocked", REQ1_READY, 0);
            check("s3_abort", ABORT, 0);
            if (REQ1_VALID && REQ1_READY) idx++;
            step();
        end
        check("s3_byte_count", wi, 8);
        {FULL, AFULL} = 2'b00;

        // Timeout: REQ0 stalls after two non-final bytes while REQ1 waits.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            REQ0_VALID = c <= 2;
            REQ0_DATA  = (c == 2) ? 8'hA1 : 8'hA0;
            REQ0_LAST  = 1'b0;
            REQ1_VALID = c <= 12;
            REQ1_DATA  = 8'hB0;
            REQ1_LAST  = 1'b1;
            @(negedge CLK);
            check($sformatf("s4 c%0d {grant,abort,write}", c), {GRANT, ABORT, WRITE},
                  {(c == 0 || c == 11 || c == 13) ? 2'b00 : (c == 12) ? 2'b10 : 2'b01,
                   c == 11, c == 2 || c == 3 || c == 13});
            if (c == 2 || c == 3 || c == 13)
                check($sformatf("s4 c%0d wdata", c), WDATA, (c == 2) ? 8'hA0 : (c == 3) ? 8'hA1 : 8'hB0);
            step();
        end
        REQ1_VALID = 1'b0;

        // Asynchronous reset in the middle of a REQ0 packet.
        do_reset();
        REQ0_VALID = 1'b1; REQ0_DATA = 8'hC0; REQ0_LAST = 1'b0;
        step(); step(); step();
        @(negedge CLK);
        check("s5_pre {grant,write}", {GRANT, WRITE}, {2'b01, 1'b1});
        #2 RST_N = 1'b0;
        #1 check("s5_async {write,grant,rdy0,abort}", {WRITE, GRANT, REQ0_READY, ABORT}, 5'b0);
        REQ0_VALID = 1'b0;
        #1 RST_N = 1'b1;
        step();
        REQ1_VALID = 1'b1; REQ1_DATA = 8'hD1; REQ1_LAST = 1'b1;
        @(negedge CLK);
        check("s5_idle grant", GRANT, 2'b00);
        step();
        @(negedge CLK);
        check("s5_req1 {grant,rdy1}", {GRANT, REQ1_READY}, {2'b10, 1'b1});
        step();
        REQ0_VALID = 1'b1; REQ0_DATA = 8'hE0; REQ0_LAST = 1'b1;
        REQ1_VALID = 1'b1; REQ1_DATA = 8'hE1; REQ1_LAST = 1'b1;
        @(negedge CLK);
        check("s5_write {grant,write,wdata}", {GRANT, WRITE, WDATA}, {2'b00, 1'b1, 8'hD1});
        step();
        @(negedge CLK);
        check("s5_tie grant", GRANT, 2'b01);
        step();
        {REQ0_VALID, REQ1_VALID} = 2'b00;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
